// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if
// Handshake and operand bundle between the ID/EX pipeline register and the
// iterative multiply/divide unit.
//   master : pipeline side, drives start, op, is_word, rs1, rs2, kill
//   slave  : ex_muldiv_seq, drives hold_req, busy, result, result_valid
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      op;
  logic            is_word;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            hold_req;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (output start, op, is_word, rs1, rs2, kill,
                  input  hold_req, busy, result, result_valid);
  modport slave  (input  start, op, is_word, rs1, rs2, kill,
                  output hold_req, busy, result, result_valid);
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
// Iterative M-extension unit for the EX stage. Radix-2 shift-add multiply and
// radix-2 restoring divide on operand magnitudes, with a sign fix-up when the
// result is formed. Holds ID/EX until the result is ready.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   bus (slave)   start/op/is_word/rs1/rs2/kill in; hold_req/busy/result/
//                 result_valid out
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on start & !kill
// S_BUSY | one iteration per cycle, counter counts N down to 1
// S_DONE | one-cycle result_valid pulse, always returns to S_IDLE
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  ex_muldiv_seq_if.slave bus
);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam int WSH = (XLEN == 64) ? 32 : 0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              wm_q, wm_d;
  logic              neg_q, neg_d;    // product / quotient needs negation
  logic              nega_q, nega_d;  // dividend negative: remainder negation
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;    // mul: {hi, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // start-cycle operand decode
  logic [2:0]      eop;
  logic            sa, sb, wm_i, is_div_i, is_rem_i;
  logic            neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val, spec_res, quo_init;

  always_comb begin
    eop      = bus.op[3] ? 3'd0 : bus.op[2:0];
    is_div_i = eop[2];
    is_rem_i = eop[2] & eop[1];
    sa       = !(eop == 3'd3 || eop == 3'd5 || eop == 3'd7);
    sb       = sa && (eop != 3'd2);
    wm_i     = bus.is_word && (XLEN == 64);
    a_ext    = bus.rs1;
    b_ext    = bus.rs2;
    if (wm_i) begin
      a_ext = sa ? sext32(bus.rs1[31:0]) : XLEN'(bus.rs1[31:0]);
      b_ext = sb ? sext32(bus.rs2[31:0]) : XLEN'(bus.rs2[31:0]);
    end
    neg_a    = sa & a_ext[XLEN-1];
    neg_b    = sb & b_ext[XLEN-1];
    mag_a    = neg_a ? -a_ext : a_ext;
    mag_b    = neg_b ? -b_ext : b_ext;
    min_val  = wm_i ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = sb && (a_ext == min_val) && (b_ext == '1);
    if (div_zero) spec_res = is_rem_i ? a_ext : '1;
    else          spec_res = is_rem_i ? '0 : a_ext;
    if (wm_i) spec_res = sext32(spec_res[31:0]);
    // word-mode dividend sits in the top half so N=32 shifts consume it
    quo_init = wm_i ? (mag_a << WSH) : mag_a;
  end

  // one iteration plus the result that would follow from it
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] acc_nx, mul_full, mul_fix;
  logic [XLEN-1:0]   mul_sel, div_sel, fin_val;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (!op_q[2])         acc_nx = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    else if (div_diff[XLEN]) acc_nx = {acc_q[2*XLEN-2:0], 1'b0};
    else                  acc_nx = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // after 32 iterations in word mode the product sits 32 bits high
    mul_full = wm_q ? (acc_nx >> WSH) : acc_nx;
    mul_fix  = neg_q ? -mul_full : mul_full;
    if (op_q == 3'd0) mul_sel = mul_fix[XLEN-1:0];
    else if (wm_q)    mul_sel = XLEN'(mul_fix[63:32]);
    else              mul_sel = mul_fix[2*XLEN-1:XLEN];

    if (op_q[1]) div_sel = nega_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    else         div_sel = neg_q  ? -acc_nx[XLEN-1:0]      : acc_nx[XLEN-1:0];

    fin_val = op_q[2] ? div_sel : mul_sel;
    if (wm_q) fin_val = sext32(fin_val[31:0]);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wm_d     = wm_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.kill) begin
          op_d   = eop;
          wm_d   = wm_i;
          neg_d  = neg_a ^ neg_b;
          nega_d = neg_a;
          cnt_d  = wm_i ? CW'(32) : CW'(XLEN);
          if (is_div_i && (div_zero || div_ovf)) begin
            result_d = spec_res;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            opnd_d  = is_div_i ? mag_b : mag_a;
            acc_d   = is_div_i ? {{XLEN{1'b0}}, quo_init} : {{XLEN{1'b0}}, mag_b};
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = fin_val;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.kill) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      wm_q     <= 1'b0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wm_q     <= wm_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // combinational so ID/EX stalls in the start cycle itself
  assign bus.hold_req     = ((state_q == S_IDLE) && bus.start && !bus.kill) || (state_q == S_BUSY);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q && !bus.kill;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.XLEN(32)) i32 ();
  ex_muldiv_seq_if #(.XLEN(64)) i64 ();

  ex_muldiv_seq #(.XLEN(32)) u32 (.clk(clk), .reset_n(reset_n), .bus(i32.slave));
  ex_muldiv_seq #(.XLEN(64)) u64 (.clk(clk), .reset_n(reset_n), .bus(i64.slave));

  int checks   = 0;
  int failures = 0;
  logic [63:0] last32;

  typedef struct {
    bit          wide;
    logic [3:0]  op;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          hold;
    bit          keep;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit wide, input bit st, input logic [3:0] op, input bit w,
                       input logic [63:0] a, input logic [63:0] b, input bit k);
    if (wide) begin
      i64.start = st; i64.op = op; i64.is_word = w; i64.rs1 = a; i64.rs2 = b; i64.kill = k;
    end else begin
      i32.start = st; i32.op = op; i32.is_word = w; i32.rs1 = a[31:0]; i32.rs2 = b[31:0]; i32.kill = k;
    end
  endtask

  function automatic logic get_hold(input bit wide);
    return wide ? i64.hold_req : i32.hold_req;
  endfunction
  function automatic logic get_valid(input bit wide);
    return wide ? i64.result_valid : i32.result_valid;
  endfunction
  function automatic logic get_busy(input bit wide);
    return wide ? i64.busy : i32.busy;
  endfunction
  function automatic logic [63:0] get_result(input bit wide);
    return wide ? i64.result : 64'(i32.result);
  endfunction

  // Reference: plain wide signed arithmetic on the N-bit operand values.
  function automatic int ref_n(input bit wide, input bit w);
    return (wide && !w) ? 64 : 32;
  endfunction

  function automatic logic [63:0] ref_op(input bit wide, input logic [3:0] op_in, input bit w,
                                         input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [2:0] op;
    bit sa, sb;
    logic signed [127:0] av, bv, pr, q, r;
    logic [63:0] res;
    n  = ref_n(wide, w);
    op = op_in[3] ? 3'd0 : op_in[2:0];
    sa = (op == 0 || op == 1 || op == 2 || op == 4 || op == 6);
    sb = (op == 0 || op == 1 || op == 4 || op == 6);
    if (n == 32) begin
      av = sa ? 128'($signed(a[31:0])) : 128'(a[31:0]);
      bv = sb ? 128'($signed(b[31:0])) : 128'(b[31:0]);
    end else begin
      av = sa ? 128'($signed(a)) : 128'(a);
      bv = sb ? 128'($signed(b)) : 128'(b);
    end
    if (!op[2]) begin
      pr  = av * bv;
      res = (op == 0) ? pr[63:0] : 64'(pr >> n);
    end else begin
      if (bv == 0) begin
        q = -1;
        r = av;
      end else begin
        q = av / bv;
        r = av % bv;
      end
      res = op[1] ? r[63:0] : q[63:0];
    end
    if (n == 32) res = wide ? 64'($signed(res[31:0])) : {32'b0, res[31:0]};
    return res;
  endfunction

  function automatic int ref_hold(input bit wide, input logic [3:0] op_in, input bit w,
                                  input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [2:0] op;
    logic [63:0] mask, an, bn, minv;
    n    = ref_n(wide, w);
    op   = op_in[3] ? 3'd0 : op_in[2:0];
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = (n == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    an   = a & mask;
    bn   = b & mask;
    if (op[2] && (bn == 0 || ((op == 4 || op == 6) && an == minv && bn == mask))) return 1;
    return n + 1;
  endfunction

  task automatic do_op(input string tag, input bit wide, input logic [3:0] op, input bit w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_hold, input bit keep);
    int hold_cnt;
    int vcyc;
    logic [63:0] got;
    hold_cnt = 0;
    vcyc     = -1;
    got      = '0;
    @(posedge clk); #1;
    drive(wide, 1'b1, op, w, a, b, 1'b0);
    @(negedge clk);
    if (get_hold(wide)) hold_cnt++;
    if (get_valid(wide)) begin vcyc = 0; got = get_result(wide); end
    for (int c = 1; c <= 80 && vcyc < 0; c++) begin
      @(posedge clk); #1;
      if (!keep)
        drive(wide, 1'b0, 4'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      @(negedge clk);
      if (get_hold(wide)) hold_cnt++;
      if (get_valid(wide)) begin vcyc = c; got = get_result(wide); end
    end
    check({tag, " result"}, got, exp);
    check({tag, " valid_cycle"}, 64'(vcyc), 64'(exp_hold));
    check({tag, " hold_cycles"}, 64'(hold_cnt), 64'(exp_hold));
    if (!wide) last32 = exp;
  endtask

  function automatic logic [63:0] pick(input bit wide);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = '1;
      2: v = wide ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: v = 64'($urandom_range(0, 15));
      4: v = {$urandom, 32'h8000_0000};
      default: ;
    endcase
    return v;
  endfunction

  function automatic vec_t mk(input bit wide, input logic [3:0] op, input bit w, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] exp, input int hold, input bit keep);
    vec_t v;
    v.wide = wide; v.op = op; v.w = w; v.a = a; v.b = b; v.exp = exp; v.hold = hold; v.keep = keep;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    bit kp;
    vecs.push_back(mk(0, 4'd0, 0, 64'h7,         64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, 0));
    vecs.push_back(mk(0, 4'd3, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, 0));
    vecs.push_back(mk(0, 4'd2, 0, 64'hFFFF_FFFF, 64'h2,         64'hFFFF_FFFF, 33, 0));
    vecs.push_back(mk(0, 4'd4, 0, 64'h7,         64'h0,         64'hFFFF_FFFF, 1,  0));
    vecs.push_back(mk(0, 4'd7, 0, 64'h7,         64'h0,         64'h7,         1,  0));
    vecs.push_back(mk(0, 4'd4, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1,  0));
    vecs.push_back(mk(0, 4'd6, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1,  0));
    vecs.push_back(mk(0, 4'd6, 0, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF, 33, 0));
    vecs.push_back(mk(0, 4'd4, 0, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD, 33, 1));
    vecs.push_back(mk(0, 4'd5, 0, 64'd100,       64'd7,         64'd14,        33, 0));
    vecs.push_back(mk(0, 4'd9, 0, 64'd5,         64'd6,         64'd30,        33, 0));
    vecs.push_back(mk(0, 4'd1, 0, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, 0));
    vecs.push_back(mk(1, 4'd4, 1, 64'h0000_0001_FFFF_FFF8, 64'h2, 64'hFFFF_FFFF_FFFF_FFFC, 33, 0));
    vecs.push_back(mk(1, 4'd0, 1, 64'h1_0000, 64'h1_0000, 64'h0, 33, 0));
    vecs.push_back(mk(1, 4'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 65, 0));
    vecs.push_back(mk(1, 4'd5, 1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 33, 0));
    vecs.push_back(mk(1, 4'd7, 1, 64'h0000_0000_8000_0007, 64'h0, 64'hFFFF_FFFF_8000_0007, 1, 0));
    vecs.push_back(mk(1, 4'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h123, 64'hFFFF_FFFF_FFFF_FEDD, 65, 0));
    vecs.push_back(mk(1, 4'd6, 1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0, 1, 0));

    reset_n = 1'b0;
    drive(0, 0, 4'd0, 0, 64'd0, 64'd0, 0);
    drive(1, 0, 4'd0, 0, 64'd0, 64'd0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int wd = 0; wd < 2; wd++) begin
      check($sformatf("reset%0d hold_req", wd), 64'(get_hold(1'(wd))), 64'd0);
      check($sformatf("reset%0d busy", wd), 64'(get_busy(1'(wd))), 64'd0);
      check($sformatf("reset%0d result_valid", wd), 64'(get_valid(1'(wd))), 64'd0);
      check($sformatf("reset%0d result", wd), get_result(1'(wd)), 64'd0);
    end
    reset_n = 1'b1;

    // reset mid-operation must abort and clear the last result
    do_op("pre_reset", 0, 4'd0, 0, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, 0);
    @(posedge clk); #1;
    drive(0, 1, 4'd5, 0, 64'd1000, 64'd3, 0);
    repeat (5) begin
      @(posedge clk); #1;
      drive(0, 0, 4'd5, 0, 64'd1000, 64'd3, 0);
    end
    #2 reset_n = 1'b0;
    #1;
    check("async_reset busy", 64'(get_busy(0)), 64'd0);
    check("async_reset result_valid", 64'(get_valid(0)), 64'd0);
    check("async_reset result", get_result(0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      do_op($sformatf("vec%0d", i), vecs[i].wide, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].hold, vecs[i].keep);

    // kill in the 10th BUSY cycle
    @(posedge clk); #1;
    drive(0, 1, 4'd0, 0, 64'd5, 64'd9, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      drive(0, 0, 4'd0, 0, 64'd5, 64'd9, c == 10);
      @(negedge clk);
    end
    check("kill_cycle result_valid", 64'(get_valid(0)), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 4'd0, 0, 64'd5, 64'd9, 0);
    @(negedge clk);
    check("after_kill busy", 64'(get_busy(0)), 64'd0);
    check("after_kill hold_req", 64'(get_hold(0)), 64'd0);
    check("after_kill result", get_result(0), last32);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (get_valid(0)) vcount++;
    end
    check("after_kill stray_valid", 64'(vcount), 64'd0);
    do_op("mul_after_kill", 0, 4'd0, 0, 64'd3, 64'd4, 64'd12, 33, 0);

    // kill in the start cycle: operation never starts
    @(posedge clk); #1;
    drive(0, 1, 4'd5, 0, 64'd100, 64'd7, 1);
    @(negedge clk);
    check("kill_start hold_req", 64'(get_hold(0)), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 4'd5, 0, 64'd100, 64'd7, 0);
    @(negedge clk);
    check("kill_start busy", 64'(get_busy(0)), 64'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (get_valid(0)) vcount++;
    end
    check("kill_start stray_valid", 64'(vcount), 64'd0);
    check("kill_start result", get_result(0), last32);

    // randomized against the reference model
    for (int i = 0; i < 200; i++) begin
      bit wide;
      bit w;
      logic [3:0] op;
      logic [63:0] a, b;
      wide = (i >= 120);
      op   = 4'($urandom);
      w    = 1'($urandom);
      a    = pick(wide);
      b    = pick(wide);
      kp   = (i != 119) && (i != 199) && ($urandom_range(0, 3) == 0);
      do_op($sformatf("rnd%0d", i), wide, op, w, a, b, ref_op(wide, op, w, a, b),
            ref_hold(wide, op, w, a, b), kp);
      if (!kp && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        drive(wide, 0, 4'd0, 0, 64'd0, 64'd0, 0);
      end
    end

    @(posedge clk); #1;
    drive(0, 0, 4'd0, 0, 64'd0, 64'd0, 0);
    drive(1, 0, 4'd0, 0, 64'd0, 64'd0, 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
